// File: rtl/lsu.sv
// Load/store unit: takes one RV32I memory instruction from execute, runs it over a
// request/grant + rvalid bus, and returns formatted load data or a fault.
module lsu #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_addr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic [31:0] wb_data_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int CNT_W = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [4:0]        rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              misalign_q, misalign_d;

  // Misaligned halfword/word, or a funct3 that is not a legal load/store size.
  function automatic logic illegal_access(input logic we, input logic [2:0] f3,
                                          input logic [1:0] a);
    logic bad;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = a[0];
      3'b010:  bad = (a != 2'b00);
      3'b100:  bad = we;
      3'b101:  bad = we | a[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] s;
    case (f3)
      3'b000:  s = 4'b0001 << a;
      3'b001:  s = 4'b0011 << a;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3)
      3'b000:  d = {4{wd[7:0]}};
      3'b001:  d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] rd);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    sh = rd >> {a, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      3'b000:  r = 32'(b);
      3'b001:  r = 32'(h);
      3'b100:  r = {24'b0, sh[7:0]};
      3'b101:  r = {16'b0, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'b0;
      addr_q     <= 32'b0;
      wdata_q    <= 32'b0;
      rd_q       <= 5'b0;
      cnt_q      <= '0;
      rdata_q    <= 32'b0;
      err_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    misalign_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d     = we_i;
          funct3_d = funct3_i;
          addr_d   = addr_i;
          wdata_d  = wdata_i;
          rd_d     = rd_addr_i;
          rdata_d  = 32'b0;
          err_d    = 1'b0;
          if (illegal_access(we_i, funct3_i, addr_i[1:0])) begin
            misalign_d = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          state_d = we_q ? DONE : WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          rdata_d = load_format(funct3_q, addr_q[1:0], mem_rdata_i);
          state_d = DONE;
        end else if (cnt_q >= CNT_LAST) begin
          rdata_d = 32'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus side is decoded from state so a reset drops the request immediately.
  assign req_ready_o  = (state_q == IDLE);
  assign stall_o      = (state_q != IDLE);
  assign mem_req_o    = (state_q == REQ);
  assign mem_we_o     = (state_q == REQ) && we_q;
  assign mem_addr_o   = (state_q == REQ) ? {addr_q[31:2], 2'b00} : 32'b0;
  assign mem_wstrb_o  = ((state_q == REQ) && we_q) ? store_strobe(funct3_q, addr_q[1:0]) : 4'b0;
  assign mem_wdata_o  = ((state_q == REQ) && we_q) ? store_lanes(funct3_q, wdata_q) : 32'b0;
  assign done_o       = (state_q == DONE);
  assign wb_valid_o   = (state_q == DONE) && !we_q && !err_q;
  assign wb_rd_addr_o = rd_q;
  assign wb_data_o    = (state_q == DONE) ? rdata_q : 32'b0;
  assign bus_err_o    = (state_q == DONE) && err_q;
  assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: loads, stores, misalignment, grant back-pressure,
// read timeout and reset abandoning a transaction.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd_addr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        done;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        misalign;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  lsu #(.MEM_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .we_i         (we),
    .funct3_i     (funct3),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .rd_addr_i    (rd_addr),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wstrb_o  (mem_wstrb),
    .mem_wdata_o  (mem_wdata),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .stall_o      (stall),
    .done_o       (done),
    .wb_valid_o   (wb_valid),
    .wb_rd_addr_o (wb_rd_addr),
    .wb_data_o    (wb_data),
    .misalign_o   (misalign),
    .bus_err_o    (bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    req_valid = 1'b1;
    we        = w;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    rd_addr   = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b1; req_valid = 1'b0; we = 1'b0; funct3 = 3'b0; addr = 32'b0;
    wdata = 32'b0; rd_addr = 5'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready",    {31'b0, req_ready}, 32'd1);
    check("rst_mem_req",  {31'b0, mem_req},   32'd0);
    check("rst_stall",    {31'b0, stall},     32'd0);
    check("rst_done",     {31'b0, done},      32'd0);
    check("rst_misalign", {31'b0, misalign},  32'd0);
    check("rst_wb_data",  wb_data,            32'd0);
    check("rst_wstrb",    {28'b0, mem_wstrb}, 32'd0);
    #19 rst_n = 1'b1;
    step();

    // LB 0x1003, grant and rvalid immediate
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h80FF_1234;
    issue(1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd7);
    check("lb_req",      {31'b0, mem_req},   32'd1);
    check("lb_addr",     mem_addr,           32'h0000_1000);
    check("lb_wstrb",    {28'b0, mem_wstrb}, 32'd0);
    check("lb_ready",    {31'b0, req_ready}, 32'd0);
    check("lb_stall",    {31'b0, stall},     32'd1);
    step();
    check("lb_req_drop", {31'b0, mem_req},   32'd0);
    check("lb_done_c2",  {31'b0, done},      32'd0);
    step();
    check("lb_done",     {31'b0, done},      32'd1);
    check("lb_wb_valid", {31'b0, wb_valid},  32'd1);
    check("lb_wb_data",  wb_data,            32'hFFFF_FF80);
    check("lb_wb_rd",    {27'b0, wb_rd_addr}, 32'd7);
    step();
    check("lb_idle",     {31'b0, req_ready}, 32'd1);
    check("lb_done_off", {31'b0, done},      32'd0);
    mem_rvalid = 1'b0;

    // SH 0x2002
    issue(1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 5'd0);
    check("sh_req",      {31'b0, mem_req},   32'd1);
    check("sh_we",       {31'b0, mem_we},    32'd1);
    check("sh_addr",     mem_addr,           32'h0000_2000);
    check("sh_wstrb",    {28'b0, mem_wstrb}, 32'hC);
    check("sh_wdata",    mem_wdata,          32'hABCD_ABCD);
    step();
    check("sh_done",     {31'b0, done},      32'd1);
    check("sh_wb_valid", {31'b0, wb_valid},  32'd0);
    step();

    // SB 0x5001
    issue(1'b1, 3'b000, 32'h0000_5001, 32'h1234_5678, 5'd0);
    check("sb_wstrb",    {28'b0, mem_wstrb}, 32'h2);
    check("sb_wdata",    mem_wdata,          32'h7878_7878);
    step();
    check("sb_done",     {31'b0, done},      32'd1);
    step();

    // LW 0x3001 misaligned
    mem_gnt = 1'b0;
    issue(1'b0, 3'b010, 32'h0000_3001, 32'h0, 5'd3);
    check("lw_mis_pulse", {31'b0, misalign},  32'd1);
    check("lw_mis_req",   {31'b0, mem_req},   32'd0);
    check("lw_mis_ready", {31'b0, req_ready}, 32'd1);
    step();
    check("lw_mis_clear", {31'b0, misalign},  32'd0);
    check("lw_mis_req2",  {31'b0, mem_req},   32'd0);
    check("lw_mis_ready2", {31'b0, req_ready}, 32'd1);

    // Store with load-only funct3 (BU) is undefined
    issue(1'b1, 3'b100, 32'h0000_3000, 32'h0, 5'd0);
    check("sbu_mis",     {31'b0, misalign},  32'd1);
    check("sbu_req",     {31'b0, mem_req},   32'd0);
    step();

    // LHU 0x4002, grant held off 5 cycles
    mem_rdata = 32'h9876_5432;
    issue(1'b0, 3'b101, 32'h0000_4002, 32'h0, 5'd9);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("lhu_req_%0d", i),   {31'b0, mem_req},   32'd1);
      check($sformatf("lhu_addr_%0d", i),  mem_addr,           32'h0000_4000);
      check($sformatf("lhu_we_%0d", i),    {31'b0, mem_we},    32'd0);
      check($sformatf("lhu_wstrb_%0d", i), {28'b0, mem_wstrb}, 32'd0);
      step();
    end
    mem_gnt = 1'b1;
    #1;
    check("lhu_req_gnt", {31'b0, mem_req},   32'd1);
    step();
    mem_gnt = 1'b0;
    check("lhu_req_drop", {31'b0, mem_req},  32'd0);
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    check("lhu_done",     {31'b0, done},     32'd1);
    check("lhu_wb_valid", {31'b0, wb_valid}, 32'd1);
    check("lhu_wb_data",  wb_data,           32'h0000_9876);
    step();

    // LH 0x8000, negative halfword
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_8001;
    issue(1'b0, 3'b001, 32'h0000_8000, 32'h0, 5'd2);
    step(); step();
    check("lh_wb_data",  wb_data,            32'hFFFF_8001);
    check("lh_done",     {31'b0, done},      32'd1);
    step();
    mem_rvalid = 1'b0;

    // LW 0x6000 without rvalid: timeout after 4 WAIT cycles
    issue(1'b0, 3'b010, 32'h0000_6000, 32'h0, 5'd4);
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_wait_done_%0d", i), {31'b0, done},  32'd0);
      check($sformatf("to_wait_stall_%0d", i), {31'b0, stall}, 32'd1);
      step();
    end
    check("to_done",     {31'b0, done},      32'd1);
    check("to_bus_err",  {31'b0, bus_err},   32'd1);
    check("to_wb_valid", {31'b0, wb_valid},  32'd0);
    check("to_wb_data",  wb_data,            32'd0);
    step();
    check("to_err_off",  {31'b0, bus_err},   32'd0);

    // Reset during WAIT
    issue(1'b0, 3'b010, 32'h0000_7000, 32'h0, 5'd5);
    step();
    check("rw_in_wait",  {31'b0, stall},     32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rw_mem_req",  {31'b0, mem_req},   32'd0);
    check("rw_stall",    {31'b0, stall},     32'd0);
    check("rw_ready",    {31'b0, req_ready}, 32'd1);
    mem_gnt = 1'b0;
    #3 rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rw_no_done_%0d", i),  {31'b0, done},     32'd0);
      check($sformatf("rw_no_wb_%0d", i),    {31'b0, wb_valid}, 32'd0);
      step();
    end
    mem_rvalid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
Parameters:
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 255, giving the maximum WAIT cycles before a bus-error completion.
Ports (`DATA_WIDTH = `RV32_ADDR_WIDTH = 32):
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-004 The block SHALL have port req_valid_i, input, 1 bit, a memory instruction presented by the execute stage.
REQ-005 The block SHALL have port req_ready_o, output, 1 bit, high only in IDLE.
REQ-006 The block SHALL have port we_i, input, 1 bit, 1 = store, 0 = load.
REQ-007 The block SHALL have port funct3_i, input, 3 bits, RV32I size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 The block SHALL have port addr_i, input, 32 bits, the effective address (ALU add result, rs1 + imm).
REQ-009 The block SHALL have port wdata_i, input, 32 bits, rs2 store data.
REQ-010 The block SHALL have port rd_addr_i, input, 5 bits, the load destination register.
REQ-011 The block SHALL have port mem_req_o, output, 1 bit, the bus request.
REQ-012 The block SHALL have port mem_we_o, output, 1 bit, the bus write enable.
REQ-013 The block SHALL have port mem_addr_o, output, 32 bits, the word-aligned bus address (low 2 bits 0).
REQ-014 The block SHALL have port mem_wstrb_o, output, 4 bits, the byte strobes.
REQ-015 The block SHALL have port mem_wdata_o, output, 32 bits, the lane-shifted write data.
REQ-016 The block SHALL have port mem_gnt_i, input, 1 bit, the bus grant.
REQ-017 The block SHALL have port mem_rvalid_i, input, 1 bit, read data valid.
REQ-018 The block SHALL have port mem_rdata_i, input, 32 bits, read data.
REQ-019 The block SHALL have port stall_o, output, 1 bit, pipeline hold, high whenever state is not IDLE.
REQ-020 The block SHALL have port done_o, output, 1 bit, a one-cycle completion pulse.
REQ-021 The block SHALL have port wb_valid_o, output, 1 bit, asserted with done_o for successful loads only.
REQ-022 The block SHALL have port wb_rd_addr_o, output, 5 bits, the captured rd.
REQ-023 The block SHALL have port wb_data_o, output, 32 bits, the formatted load result.
REQ-024 The block SHALL have port misalign_o, output, 1 bit, a one-cycle misaligned-access exception pulse.
REQ-025 The block SHALL have port bus_err_o, output, 1 bit, a one-cycle timeout-error pulse coincident with done_o.

Function
REQ-026 The block SHALL implement FSM states IDLE, REQ, WAIT, DONE, with all outputs registered or decoded from state and captured registers only.
REQ-027 In IDLE with req_valid_i=1, the block SHALL capture we_i, funct3_i, addr_i, wdata_i, rd_addr_i; req_valid_i in any other state SHALL be ignored.
REQ-028 A misaligned access (H/HU with addr[0]=1; W with addr[1:0]!=0) or an undefined funct3 (011, 110, 111; store funct3 >010) SHALL pulse misalign_o the next cycle, issue no bus request, and remain in IDLE.
REQ-029 An aligned access SHALL go to REQ, where mem_req_o=1 holds with stable mem_we_o/mem_addr_o/mem_wstrb_o/mem_wdata_o until mem_gnt_i=1.
REQ-030 Store strobes: B -> 4'b0001<<addr[1:0], H -> 4'b0011<<addr[1:0], W -> 4'b1111; for reads mem_wstrb_o SHALL be 0.
REQ-031 mem_wdata_o SHALL be the replicated byte/halfword or the full word, respectively, so each lane carries the correct data.
REQ-032 On grant in REQ, a store SHALL go to DONE and a load SHALL go to WAIT; mem_req_o SHALL deassert in the cycle after grant.
REQ-033 mem_rvalid_i SHALL be honoured only in WAIT; on it the block SHALL select the lane by addr[1:0], zero-extend (BU/HU) or sign-extend (B/H) into wb_data_o, and go to DONE.
REQ-034 The WAIT cycle counter SHALL be 8+ bits; when it reaches MEM_TIMEOUT without rvalid, the block SHALL go to DONE with bus_err_o=1, wb_valid_o=0, and wb_data_o=0.
REQ-035 DONE SHALL last exactly one cycle (done_o=1, wb_valid_o per REQ-021), then return to IDLE; the minimum load latency is accept + 3 cycles, and the minimum store latency is accept + 2 cycles.

Reset
REQ-036 On rst_n=0, the block SHALL immediately, and independent of clk, go to IDLE with every output 0 except req_ready_o=1, and clear the counter and captured registers.
REQ-037 Reset asserted mid-transaction (REQ/WAIT) SHALL abandon it, drop mem_req_o at once, and produce no done_o after release.

Verification
REQ-038 The bench SHALL cover: LB addr=0x1003, rdata=0x80FF_1234, gnt and rvalid immediate -> wb_data_o=0xFFFF_FF80, wb_valid_o=1, 3 cycles after accept.
REQ-039 The bench SHALL cover: SH addr=0x2002, wdata=0x0000_ABCD -> mem_addr_o=0x2000, wstrb=1100, mem_wdata_o=0xABCD_ABCD, done_o with no wb_valid_o.
REQ-040 The bench SHALL cover: LW addr=0x3001 -> misalign_o=1 for 1 cycle, mem_req_o never asserted, req_ready_o stays 1.
REQ-041 The bench SHALL cover: LHU addr=0x4002, gnt delayed 5 cycles -> request signals stable for all 5 cycles; rdata=0x9876_5432 -> wb_data_o=0x0000_9876.
REQ-042 The bench SHALL cover: LW with no rvalid and MEM_TIMEOUT=4 -> bus_err_o and done_o after 4 WAIT cycles, wb_valid_o=0.
REQ-043 The bench SHALL cover: rst_n low during WAIT -> mem_req_o=0 and stall_o=0 immediately, a later rvalid is ignored, and no done_o occurs.
